green_ins_encoder: RTL and testbench
====================================

GREEN_INS_ENCODER -- requirements
Module: green_ins_encoder

Interface
REQ-001 Parameter DEPTH, default 4: request FIFO depth in entries, power of two, 2 to 16.
REQ-002 Parameter BR_WAIT, default 2: cycles held in branch wait after a branch word is accepted, 1 to 15.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 req_valid  input  1  requester offers an operation.
REQ-006 req_ready  output  1  encoder accepts the operation this cycle.
REQ-007 req_op  input  2  operation select: 0 load, 1 store, 2 increment, 3 branch.
REQ-008 req_sel  input  1  register select: 0 for RA, 1 for RB.
REQ-009 req_imm  input  11  operand field.
REQ-010 ins  output  16  encoded instruction word, registered.
REQ-011 ins_valid  output  1  ins holds a valid word.
REQ-012 ins_ready  input  1  downstream decoder stage consumes ins.
REQ-013 br_flag  input  1  branch outcome returned by the decoder side; 1 means taken.
REQ-014 flush  output  1  one-cycle pulse when queued words are discarded after a taken branch.
REQ-015 ins_count  output  8  count of words accepted by downstream, wrapping.

Function
REQ-016 Encoding SHALL be: ins[15:12] = {2'b00, req_op}; ins[11] = req_sel; ins[10:0] = req_imm. Opcodes are 0000 LD, 0001 ST, 0010 INC, 0011 BR.
REQ-017 req_ready SHALL be 1 only when the FIFO is not full, state is RUN, and flush is 0; it is combinational from registered state only.
REQ-018 A request SHALL be accepted when req_valid && req_ready; the encoded word is written to the FIFO tail at that edge.
REQ-019 Push when full SHALL be impossible, even if a pop occurs in the same cycle; no overflow is permitted.
REQ-020 The output register SHALL load the FIFO head when all of these hold: state RUN; FIFO not empty; (!ins_valid || ins_ready).
REQ-021 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-022 Latency: with the FIFO empty and ins_valid 0, a word accepted at edge N SHALL appear on ins with ins_valid=1 after edge N+1.
REQ-023 While ins_valid && !ins_ready, ins and ins_valid SHALL hold stable.
REQ-024 ins_valid SHALL clear on consumption unless a new word is loaded in the same cycle; back-to-back issue is one word per cycle.
REQ-025 FSM states are RUN and BRW.
REQ-026 RUN -> BRW SHALL occur on consumption of a word with ins[15:12] = 0011; the wait counter loads BR_WAIT at that edge.
REQ-027 In BRW, no FIFO pop and no request acceptance SHALL occur; the counter decrements by 1 each cycle.
REQ-028 In BRW, in the cycle the counter equals 1, br_flag SHALL be sampled, and the state returns to RUN at the next edge.
REQ-029 If br_flag is 1 at that sample, FIFO occupancy SHALL be zeroed (pointers reset) at the same edge, and flush SHALL pulse high for the following cycle.
REQ-030 If br_flag is 0 at that sample, queued words SHALL be retained and issue resumes in RUN.
REQ-031 ins_count SHALL increment by 1 on each ins_valid && ins_ready, and wrap from 255 to 0.

Reset
REQ-032 While rst_n = 0 at a rising edge, the block SHALL reset to: state RUN; FIFO empty; ins = 16'h0000; ins_valid = 0; flush = 0; ins_count = 0; wait counter = 0.
REQ-033 Reset mid-operation, including during BRW or with ins stalled, SHALL discard all queued and pending words without emitting them.
REQ-034 req_ready SHALL be 0 in any cycle where rst_n is sampled 0.

Verification
REQ-035 Bench SHALL cover: reset, then push op=2, sel=1, imm=0x005 with ins_ready=1 -> ins = 0x2805, ins_valid=1 after the second edge, ins_count = 1.
REQ-036 Bench SHALL cover: ins_ready=0, push 5 words with DEPTH=4 -> one word held on ins, 4 words queued, req_ready=0; then ins_ready=1 -> 5 words drained in order, one per cycle.
REQ-037 Bench SHALL cover: push BR (0x3000) then LD (0x0123), br_flag=1 -> after BR is consumed, 2 cycles in BRW, flush pulses, and 0x0123 is never issued.
REQ-038 Bench SHALL cover: the same sequence with br_flag=0 -> 0x0123 is issued in the cycle after BRW exits.
REQ-039 Bench SHALL cover: simultaneous push and pop at occupancy 2 for 10 cycles -> occupancy stays 2, words in order, pointer wrap exercised.
REQ-040 Bench SHALL cover: rst_n low during BRW with 3 words queued -> all outputs at reset values next cycle, no queued word ever appears on ins.

Source files
------------

// File: rtl/green_ins_encoder.sv
// rtl/green_ins_encoder.sv - request FIFO plus registered instruction word encoder with branch wait/flush
module green_ins_encoder #(
  parameter int DEPTH   = 4,
  parameter int BR_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_sel,
  input  logic [10:0] req_imm,
  output logic [15:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        br_flag,
  output logic        flush,
  output logic [7:0]  ins_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [3:0]  OP_BR    = 4'b0011;

  typedef enum logic {RUN, BRW} state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    wait_cnt;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        consume;
  logic        consume_br;
  logic [15:0] enc;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign enc        = {2'b00, req_op, req_sel, req_imm};
  assign req_ready  = rst_n && (state == RUN) && !full && !flush;
  assign push       = req_valid && req_ready;
  assign consume    = ins_valid && ins_ready;
  assign consume_br = consume && (ins[15:12] == OP_BR);
  // The edge that retires a branch is the first edge of the wait: nothing behind it may be issued.
  assign pop        = (state == RUN) && !empty && (!ins_valid || ins_ready) && !consume_br;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ins       <= 16'h0000;
      ins_valid <= 1'b0;
      flush     <= 1'b0;
      ins_count <= 8'd0;
      wait_cnt  <= 4'd0;
    end else begin
      flush <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        ins       <= mem[rd_ptr];
        ins_valid <= 1'b1;
      end else if (consume) begin
        ins_valid <= 1'b0;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (consume) begin
        ins_count <= ins_count + 8'd1;
      end

      case (state)
        RUN: begin
          if (consume_br) begin
            state    <= BRW;
            wait_cnt <= 4'(BR_WAIT);
          end
        end
        BRW: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= RUN;
            // Taken branch: everything queued behind it belongs to the wrong path.
            if (br_flag) begin
              wr_ptr <= '0;
              rd_ptr <= '0;
              count  <= '0;
              flush  <= 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_green_ins_encoder.sv
// tb/tb_green_ins_encoder.sv - directed scoreboard bench for green_ins_encoder
module tb_green_ins_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_sel;
  logic [10:0] req_imm;
  logic [15:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        br_flag;
  logic        flush;
  logic [7:0]  ins_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb [$];
  logic [7:0]  cnt_model = 8'd0;
  logic [15:0] w0;

  green_ins_encoder #(.DEPTH(4), .BR_WAIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_sel   (req_sel),
    .req_imm   (req_imm),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .br_flag   (br_flag),
    .flush     (flush),
    .ins_count (ins_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic s, input logic [10:0] imm);
    req_valid = v;
    req_op    = op;
    req_sel   = s;
    req_imm   = imm;
  endtask

  // Score the upcoming edge at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic [15:0] exp;
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (ins_valid === 1'b1 && ins_ready === 1'b1) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_issue: got %h expected none", ins);
        end
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          chk("issue_order", ins, exp);
        end
        cnt_model = cnt_model + 8'd1;
      end
      if (req_valid === 1'b1 && req_ready === 1'b1) begin
        sb.push_back({2'b00, req_op, req_sel, req_imm});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ins_ready = 1'b0;
    br_flag = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 11'd0);
    tick();
    tick();
    chk("rst_ins", ins, 16'h0000);
    chk("rst_ins_valid", {15'd0, ins_valid}, 16'd0);
    chk("rst_flush", {15'd0, flush}, 16'd0);
    chk("rst_ins_count", {8'd0, ins_count}, 16'd0);
    chk("rst_req_ready", {15'd0, req_ready}, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {15'd0, req_ready}, 16'd1);

    // Single word: accepted at edge N, visible after N+1
    ins_ready = 1'b1;
    drive(1'b1, 2'd2, 1'b1, 11'h005);
    tick();
    drive(1'b0, 2'd0, 1'b0, 11'd0);
    chk("lat_not_yet", {15'd0, ins_valid}, 16'd0);
    tick();
    chk("lat_ins", ins, 16'h2805);
    chk("lat_valid", {15'd0, ins_valid}, 16'd1);
    tick();
    chk("lat_count", {8'd0, ins_count}, 16'd1);
    chk("lat_valid_clr", {15'd0, ins_valid}, 16'd0);

    // Fill with downstream stalled: one held on ins, four queued
    ins_ready = 1'b0;
    w0 = {4'b0000, 1'b0, 11'h010};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i % 3), 1'b0, 11'h010 + 11'(i));
      #1;
      chk("fill_ready", {15'd0, req_ready}, 16'd1);
      tick();
    end
    chk("full_ready", {15'd0, req_ready}, 16'd0);
    chk("full_head", ins, w0);
    chk("full_valid", {15'd0, ins_valid}, 16'd1);
    drive(1'b1, 2'd1, 1'b1, 11'h7ff);
    tick();
    tick();
    drive(1'b0, 2'd0, 1'b0, 11'd0);
    chk("stall_hold", ins, w0);
    chk("stall_valid", {15'd0, ins_valid}, 16'd1);
    ins_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_last_valid", {15'd0, ins_valid}, 16'd1);
    tick();
    chk("drain_done_valid", {15'd0, ins_valid}, 16'd0);
    chk("drain_sb_empty", 16'(sb.size()), 16'd0);
    chk("drain_count", {8'd0, ins_count}, {8'd0, cnt_model});

    // Taken branch: LD behind it is discarded
    br_flag = 1'b1;
    drive(1'b1, 2'd3, 1'b0, 11'h000);
    tick();
    drive(1'b1, 2'd0, 1'b0, 11'h123);
    tick();
    drive(1'b0, 2'd0, 1'b0, 11'd0);
    chk("brt_ins", ins, 16'h3000);
    tick();
    chk("brt_w1_ready", {15'd0, req_ready}, 16'd0);
    chk("brt_w1_valid", {15'd0, ins_valid}, 16'd0);
    tick();
    chk("brt_w2_ready", {15'd0, req_ready}, 16'd0);
    chk("brt_w2_valid", {15'd0, ins_valid}, 16'd0);
    sb.delete();
    tick();
    chk("brt_flush", {15'd0, flush}, 16'd1);
    chk("brt_flush_ready", {15'd0, req_ready}, 16'd0);
    tick();
    chk("brt_flush_end", {15'd0, flush}, 16'd0);
    chk("brt_ready_back", {15'd0, req_ready}, 16'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("brt_no_issue", {15'd0, ins_valid}, 16'd0);

    // Not-taken branch: LD issues right after the wait ends
    br_flag = 1'b0;
    drive(1'b1, 2'd3, 1'b0, 11'h000);
    tick();
    drive(1'b1, 2'd0, 1'b0, 11'h123);
    tick();
    drive(1'b0, 2'd0, 1'b0, 11'd0);
    tick();
    tick();
    tick();
    chk("brn_flush", {15'd0, flush}, 16'd0);
    chk("brn_not_yet", {15'd0, ins_valid}, 16'd0);
    tick();
    chk("brn_ld", ins, 16'h0123);
    chk("brn_ld_valid", {15'd0, ins_valid}, 16'd1);
    tick();
    chk("brn_sb_empty", 16'(sb.size()), 16'd0);

    // Steady push+pop at occupancy 2 across pointer wrap
    ins_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i % 3), 1'b1, 11'h200 + 11'(i));
      tick();
    end
    ins_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'(i % 3), 1'(i & 1), 11'h300 + 11'(i * 7));
      #1;
      chk("steady_ready", {15'd0, req_ready}, 16'd1);
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, 11'd0);
    tick();
    tick();
    chk("steady_tail_valid", {15'd0, ins_valid}, 16'd1);
    tick();
    chk("steady_empty", {15'd0, ins_valid}, 16'd0);
    chk("steady_sb", 16'(sb.size()), 16'd0);
    chk("steady_count", {8'd0, ins_count}, {8'd0, cnt_model});

    // Reset while in branch wait with three words queued
    ins_ready = 1'b0;
    br_flag = 1'b0;
    drive(1'b1, 2'd3, 1'b0, 11'h001);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 1'b0, 11'h400 + 11'(i));
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, 11'd0);
    ins_ready = 1'b1;
    tick();
    chk("rbw_in_brw", {15'd0, req_ready}, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("rbw_ready_rst", {15'd0, req_ready}, 16'd0);
    sb.delete();
    cnt_model = 8'd0;
    tick();
    chk("rbw_ins", ins, 16'h0000);
    chk("rbw_valid", {15'd0, ins_valid}, 16'd0);
    chk("rbw_flush", {15'd0, flush}, 16'd0);
    chk("rbw_count", {8'd0, ins_count}, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("rbw_no_issue", {15'd0, ins_valid}, 16'd0);
    chk("rbw_ready", {15'd0, req_ready}, 16'd1);
    chk("rbw_count_end", {8'd0, ins_count}, {8'd0, cnt_model});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
